// File: rtl/frame_scheduler.sv
// frame_scheduler: frame sync, sequence numbering and in-order channel drain.
// Optional stall timeout with pad words is enabled by FRAME_SCHED_TIMEOUT_EN.
module frame_scheduler #(
  parameter int CH_NUM  = 4,
  parameter int LEN_W   = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [CH_NUM-1:0]       i_ch_en,
  input  logic [CH_NUM*LEN_W-1:0] i_ch_len,
  output logic                    o_hdr_sync,
  output logic [31:0]             o_sync_counter,
  output logic [15:0]             o_frame_len,
  input  logic [CH_NUM*32-1:0]    i_ch_data,
  input  logic [CH_NUM-1:0]       i_ch_vld,
  output logic [CH_NUM-1:0]       o_ch_rdy,
  output logic [31:0]             o_frame_data,
  output logic                    o_frame_vld,
  input  logic                    i_frame_rdy,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overrun,
  output logic                    o_timeout
);

  localparam int IDX_W = $clog2(CH_NUM + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEL,
    CHAN,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        ch_idx_q, ch_idx_d;
  logic [LEN_W-1:0]        word_cnt_q, word_cnt_d;
  logic [CH_NUM-1:0]       en_q, en_d;
  logic [CH_NUM*LEN_W-1:0] len_q, len_d;
  logic [31:0]             sync_cnt_q, sync_cnt_d;
  logic [15:0]             frame_len_q, frame_len_d;
  logic                    hdr_sync_q, hdr_sync_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    timeout_q, timeout_d;

  logic [31:0]      cur_data;
  logic             cur_vld;
  logic             cur_en;
  logic [LEN_W-1:0] cur_len;
  logic [15:0]      len_sum;
  logic             xfer;
  logic             pad;

  always_comb begin
    cur_data = '0;
    cur_vld  = 1'b0;
    cur_en   = 1'b0;
    cur_len  = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_idx_q == IDX_W'(i)) begin
        cur_data = i_ch_data[i*32 +: 32];
        cur_vld  = i_ch_vld[i];
        cur_en   = en_q[i];
        cur_len  = len_q[i*LEN_W +: LEN_W];
      end
    end
  end

  always_comb begin
    len_sum = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (i_ch_en[i]) begin
        len_sum = len_sum + 16'(i_ch_len[i*LEN_W +: LEN_W]);
      end
    end
  end

  always_comb begin
    o_frame_data = '0;
    o_frame_vld  = 1'b0;
    o_ch_rdy     = '0;
    if (state_q == CHAN) begin
      if (pad) begin
        o_frame_data = 32'hDEAD_BEEF;
        o_frame_vld  = 1'b1;
      end else begin
        o_frame_data = cur_data;
        o_frame_vld  = cur_vld;
        for (int i = 0; i < CH_NUM; i++) begin
          if (ch_idx_q == IDX_W'(i)) begin
            o_ch_rdy[i] = i_frame_rdy;
          end
        end
      end
    end
  end

  assign xfer      = o_frame_vld && i_frame_rdy;
  assign o_overrun = i_start && (state_q != IDLE);

`ifdef FRAME_SCHED_TIMEOUT_EN
  localparam int STL_W = $clog2(TIMEOUT + 1);

  logic [STL_W-1:0] stall_q, stall_d;
  logic             pad_q, pad_d;

  assign pad = pad_q;
`else
  logic unused_timeout;

  assign pad            = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    word_cnt_d  = word_cnt_q;
    en_d        = en_q;
    len_d       = len_q;
    sync_cnt_d  = sync_cnt_q;
    frame_len_d = frame_len_q;
    timeout_d   = timeout_q;
    hdr_sync_d  = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          en_d        = i_ch_en;
          len_d       = i_ch_len;
          sync_cnt_d  = sync_cnt_q + 32'd1;
          frame_len_d = len_sum;
          ch_idx_d    = '0;
          word_cnt_d  = '0;
          timeout_d   = 1'b0;
          hdr_sync_d  = 1'b1;
          state_d     = SYNC;
        end
      end
      SYNC: begin
        state_d = SEL;
      end
      SEL: begin
        if (ch_idx_q == IDX_W'(CH_NUM)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (cur_en && cur_len != '0) begin
          state_d = CHAN;
        end else begin
          ch_idx_d = ch_idx_q + IDX_W'(1);
          // skipping the last channel ends the frame without an extra cycle
          if (ch_idx_q == IDX_W'(CH_NUM - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      CHAN: begin
        if (xfer) begin
          if (word_cnt_q == cur_len - LEN_W'(1)) begin
            word_cnt_d = '0;
            ch_idx_d   = ch_idx_q + IDX_W'(1);
            state_d    = SEL;
          end else begin
            word_cnt_d = word_cnt_q + LEN_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef FRAME_SCHED_TIMEOUT_EN
    stall_d = stall_q;
    pad_d   = pad_q;
    if (state_q != CHAN || state_d != CHAN) begin
      stall_d = '0;
      pad_d   = 1'b0;
    end else if (xfer) begin
      stall_d = '0;
    end else if (!pad_q && !cur_vld) begin
      if (stall_q == STL_W'(TIMEOUT - 1)) begin
        stall_d   = '0;
        pad_d     = 1'b1;
        timeout_d = 1'b1;
      end else begin
        stall_d = stall_q + STL_W'(1);
      end
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_idx_q    <= '0;
      word_cnt_q  <= '0;
      en_q        <= '0;
      len_q       <= '0;
      sync_cnt_q  <= '0;
      frame_len_q <= '0;
      hdr_sync_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef FRAME_SCHED_TIMEOUT_EN
      stall_q     <= '0;
      pad_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      word_cnt_q  <= word_cnt_d;
      en_q        <= en_d;
      len_q       <= len_d;
      sync_cnt_q  <= sync_cnt_d;
      frame_len_q <= frame_len_d;
      hdr_sync_q  <= hdr_sync_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
`ifdef FRAME_SCHED_TIMEOUT_EN
      stall_q     <= stall_d;
      pad_q       <= pad_d;
`endif
    end
  end

  assign o_hdr_sync     = hdr_sync_q;
  assign o_sync_counter = sync_cnt_q;
  assign o_frame_len    = frame_len_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;
  assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed checks of sync, drain order, overrun, wrap, reset.
// Define FRAME_SCHED_TIMEOUT_EN to also cover stall padding.
`timescale 1ns/1ps
module tb_frame_scheduler;

  localparam int CH_NUM  = 4;
  localparam int LEN_W   = 12;
  localparam int TIMEOUT = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    i_start;
  logic [CH_NUM-1:0]       i_ch_en;
  logic [CH_NUM*LEN_W-1:0] i_ch_len;
  logic                    o_hdr_sync;
  logic [31:0]             o_sync_counter;
  logic [15:0]             o_frame_len;
  logic [CH_NUM*32-1:0]    i_ch_data;
  logic [CH_NUM-1:0]       i_ch_vld;
  logic [CH_NUM-1:0]       o_ch_rdy;
  logic [31:0]             o_frame_data;
  logic                    o_frame_vld;
  logic                    i_frame_rdy;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_overrun;
  logic                    o_timeout;

  frame_scheduler #(
    .CH_NUM (CH_NUM),
    .LEN_W  (LEN_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_ch_en       (i_ch_en),
    .i_ch_len      (i_ch_len),
    .o_hdr_sync    (o_hdr_sync),
    .o_sync_counter(o_sync_counter),
    .o_frame_len   (o_frame_len),
    .i_ch_data     (i_ch_data),
    .i_ch_vld      (i_ch_vld),
    .o_ch_rdy      (o_ch_rdy),
    .o_frame_data  (o_frame_data),
    .o_frame_vld   (o_frame_vld),
    .i_frame_rdy   (i_frame_rdy),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_overrun     (o_overrun),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  int unsigned       seq [CH_NUM] = '{default: 0};
  logic [CH_NUM-1:0] pop = '0;
  logic [31:0]       got [$];
  int                n_sync = 0;
  int                n_done = 0;
  int                n_vld = 0;
  int                cyc = 0;
  int                sync_cyc = 0;
  int                done_cyc = 0;
  int                n_err = 0;
  int                n_chk = 0;

  always_comb begin
    i_ch_data = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      i_ch_data[c*32 +: 32] = {8'(c), seq[c][23:0]};
    end
  end

  always @(negedge clk) begin
    cyc++;
    pop = rst_n ? (o_ch_rdy & i_ch_vld) : '0;
    if (rst_n) begin
      if (o_hdr_sync) begin
        n_sync++;
        sync_cyc = cyc;
      end
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (o_frame_vld) n_vld++;
      if (o_frame_vld && i_frame_rdy) got.push_back(o_frame_data);
    end
  end

  always @(posedge clk) begin
    #1;
    for (int c = 0; c < CH_NUM; c++) begin
      if (pop[c]) seq[c]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] w(input int c, input int unsigned s);
    return {8'(c), s[23:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [CH_NUM-1:0] en,
                             input logic [CH_NUM*LEN_W-1:0] lens);
    i_ch_en  = en;
    i_ch_len = lens;
    i_start  = 1'b1;
    step();
    i_start  = 1'b0;
  endtask

  // mode 0: all valid, ready high; 1: ready toggles, ch0 valid gaps;
  // 2: ch1 offers a single word and then stalls
  task automatic run_frame(input int mode, input int fs);
    int d0 = n_done;
    bit ok = 1'b0;
    logic [15:0] pat = 16'b1011_0110_1101_0011;
    for (int k = 0; k < 300; k++) begin
      i_ch_vld    = '1;
      i_frame_rdy = 1'b1;
      if (mode == 1) begin
        i_frame_rdy = ((k % 2) == 0);
        i_ch_vld[0] = pat[k % 16];
      end else if (mode == 2) begin
        i_ch_vld[1] = ((got.size() - fs) < 1);
      end
      step();
      if (n_done != d0) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_end", 32'(ok), 32'd1);
    i_ch_vld    = '1;
    i_frame_rdy = 1'b1;
  endtask

  task automatic check_words(input string tag, input int fs,
                             input logic [31:0] exp_q [$]);
    check({tag, "_count"}, got.size() - fs, exp_q.size());
    for (int i = 0; i < exp_q.size() && fs + i < got.size(); i++) begin
      check(tag, got[fs+i], exp_q[i]);
    end
  endtask

  logic [CH_NUM*LEN_W-1:0] lens;
  logic [31:0]             exp_q [$];
  int                      fs, d0, s0, v0;
  int unsigned             b0, b1, b2;
  bit                      seen;

  initial begin
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_ch_en     = '0;
    i_ch_len    = '0;
    i_ch_vld    = '1;
    i_frame_rdy = 1'b1;
    lens        = {12'd5, 12'd2, 12'd7, 12'd3};
    repeat (3) step();

    check("rst_sync_counter", o_sync_counter, 32'd0);
    check("rst_frame_len", 32'(o_frame_len), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_hdr_sync", 32'(o_hdr_sync), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_frame_vld", 32'(o_frame_vld), 32'd0);
    check("rst_ch_rdy", 32'(o_ch_rdy), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    rst_n = 1'b1;
    step();

    // basic frame: ch0 x3, ch2 x2, ch1/ch3 masked off
    fs = got.size(); b0 = seq[0]; b2 = seq[2]; d0 = n_done; s0 = n_sync;
    start_frame(4'b0101, lens);
    check("t1_hdr_sync", 32'(o_hdr_sync), 32'd1);
    check("t1_sync_counter", o_sync_counter, 32'd1);
    check("t1_frame_len", 32'(o_frame_len), 32'd5);
    check("t1_busy", 32'(o_busy), 32'd1);
    run_frame(0, fs);
    exp_q = {w(0, b0), w(0, b0 + 1), w(0, b0 + 2), w(2, b2), w(2, b2 + 1)};
    check_words("t1_word", fs, exp_q);
    step(); step();
    check("t1_done_once", n_done - d0, 32'd1);
    check("t1_sync_once", n_sync - s0, 32'd1);
    check("t1_idle", 32'(o_busy), 32'd0);

    // same frame under back-pressure and valid gaps
    fs = got.size(); b0 = seq[0]; b2 = seq[2];
    start_frame(4'b0101, lens);
    check("t2_sync_counter", o_sync_counter, 32'd2);
    check("t2_frame_len", 32'(o_frame_len), 32'd5);
    run_frame(1, fs);
    exp_q = {w(0, b0), w(0, b0 + 1), w(0, b0 + 2), w(2, b2), w(2, b2 + 1)};
    check_words("t2_word", fs, exp_q);

    // empty frame, overrun in SEL and DONE, start on first IDLE after DONE
    fs = got.size(); v0 = n_vld;
    start_frame(4'b0000, lens);
    check("t3_hdr_sync", 32'(o_hdr_sync), 32'd1);
    check("t3_sync_counter", o_sync_counter, 32'd3);
    check("t3_frame_len", 32'(o_frame_len), 32'd0);
    step();
    i_start = 1'b1;
    #1;
    check("t3_overrun_sel", 32'(o_overrun), 32'd1);
    i_start = 1'b0;
    step();
    check("t3_counter_hold", o_sync_counter, 32'd3);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("t3_done_seen", 32'(seen), 32'd1);
    i_start = 1'b1;
    #1;
    check("t3_overrun_done", 32'(o_overrun), 32'd1);
    step();
    check("t3_done_latency", done_cyc - sync_cyc, 32'd5);
    check("t3_idle_no_overrun", 32'(o_overrun), 32'd0);
    check("t3_idle_busy", 32'(o_busy), 32'd0);
    step();
    i_start = 1'b0;
    check("t3_restart_sync", 32'(o_hdr_sync), 32'd1);
    check("t3_restart_counter", o_sync_counter, 32'd4);
    run_frame(0, fs);
    check("t3_no_vld", n_vld - v0, 32'd0);
    check("t3_no_words", got.size() - fs, 32'd0);

    // sequence number wrap
    force dut.sync_cnt_q = 32'hFFFF_FFFF;
    step(); step();
    release dut.sync_cnt_q;
    step();
    check("t4_preset", o_sync_counter, 32'hFFFF_FFFF);
    fs = got.size();
    start_frame(4'b0000, lens);
    check("t4_wrap", o_sync_counter, 32'd0);
    run_frame(0, fs);

    // reset in the middle of a stalled channel
    i_ch_vld = '0;
    start_frame(4'b0001, {12'd0, 12'd0, 12'd0, 12'd10});
    check("t5_sync_counter", o_sync_counter, 32'd1);
    repeat (3) step();
    check("t5_chan_busy", 32'(o_busy), 32'd1);
    check("t5_chan_rdy", 32'(o_ch_rdy), 32'd1);
    check("t5_chan_vld", 32'(o_frame_vld), 32'd0);
    d0 = n_done; s0 = n_sync;
    rst_n = 1'b0;
    step();
    check("t5_rst_busy", 32'(o_busy), 32'd0);
    check("t5_rst_counter", o_sync_counter, 32'd0);
    check("t5_rst_ch_rdy", 32'(o_ch_rdy), 32'd0);
    rst_n    = 1'b1;
    i_ch_vld = '1;
    step(); step();
    check("t5_no_done", n_done - d0, 32'd0);
    check("t5_no_sync", n_sync - s0, 32'd0);
    fs = got.size(); b0 = seq[0]; b2 = seq[2];
    start_frame(4'b0101, lens);
    check("t5_restart_counter", o_sync_counter, 32'd1);
    run_frame(0, fs);
    exp_q = {w(0, b0), w(0, b0 + 1), w(0, b0 + 2), w(2, b2), w(2, b2 + 1)};
    check_words("t5_word", fs, exp_q);

`ifdef FRAME_SCHED_TIMEOUT_EN
    // ch1 stalls after one word and is padded out
    fs = got.size(); b1 = seq[1];
    start_frame(4'b0010, {12'd0, 12'd0, 12'd4, 12'd0});
    check("t6_frame_len", 32'(o_frame_len), 32'd4);
    run_frame(2, fs);
    exp_q = {w(1, b1), 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    check_words("t6_word", fs, exp_q);
    check("t6_timeout_set", 32'(o_timeout), 32'd1);
    fs = got.size();
    start_frame(4'b0000, lens);
    check("t6_timeout_clr", 32'(o_timeout), 32'd0);
    run_frame(0, fs);
`else
    b1 = 0;
    check("t6_no_timeout", 32'(o_timeout), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
